// File: rtl/best_arr_out_sched.sv
// -----------------------------------------------------------------------------
// best_arr_out_sched
//
// Streams the best-match index array out of the best-array SRAM into the
// output FIFO once the search has finished. The memory is walked in host
// order: half-row px, column block x, row y, in-block column xi. Each stored
// index is zero-extended to one FIFO word. The design honours FIFO
// backpressure through a 2-entry skid buffer.
//
// The word arriving on rd_data counts as a valid skid entry in the cycle it
// arrives. It is forwarded straight to the FIFO when the buffer is empty and
// the FIFO can accept it. This gives one word per cycle, and the first enqueue
// comes two cycles after the start pulse.
//
// Ports
//   clk, rst_n     core clock, async active-low reset
//   send_best_arr  start pulse, only sampled in IDLE
//   busy           high from the start cycle until done
//   done           one-cycle pulse after the last word is enqueued
//   rd_en/rd_addr  best-array read request
//   rd_data        read data, valid one cycle after rd_en
//   fifo_wenq      output FIFO enqueue
//   fifo_wdata     output FIFO word {zeros, index}
//   fifo_wfull_n   FIFO can accept a word this cycle
//   stall_cycles   (only with OUTSCHED_STALL_CNT_EN) counts the cycles in
//                  which a word is held back by fifo_wfull_n
//
// Optional feature macro: OUTSCHED_STALL_CNT_EN
// -----------------------------------------------------------------------------
module best_arr_out_sched #(
  parameter int DATA_WIDTH = 11,
  parameter int IDX_WIDTH  = 9,
  parameter int ROW_SIZE   = 26,
  parameter int COL_SIZE   = 19,
  parameter int BLOCKING   = 4,
  parameter int ADDRW      = $clog2(ROW_SIZE*COL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_best_arr,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDRW-1:0]      rd_addr,
  input  logic [IDX_WIDTH-1:0]  rd_data,
  output logic                  fifo_wenq,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull_n
`ifdef OUTSCHED_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int HALF  = ROW_SIZE / 2;
  localparam int NBLK  = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int LASTW = HALF - (NBLK - 1) * BLOCKING;
  localparam int XW    = (NBLK > 1)     ? $clog2(NBLK)     : 1;
  localparam int YW    = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam int XIW   = (BLOCKING > 1) ? $clog2(BLOCKING) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Loop counters
  logic           px;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [XIW-1:0] xi;
  logic [XIW-1:0] xi_last;
  logic           last_addr;

  // Skid buffer. skid[0] is the head.
  logic [IDX_WIDTH-1:0] skid [2];
  logic [1:0]           skid_cnt;
  logic                 inflight;   // a read was issued last cycle
  logic [1:0]           occ;        // buffered words plus the word arriving now
  logic                 head_valid;
  logic [IDX_WIDTH-1:0] head_data;
  logic                 pop_buf;
  logic                 push;

  // The last block of a half-row may be narrower. Columns past the half-row
  // are never visited, so they cost no cycle.
  assign xi_last   = (x == XW'(NBLK - 1)) ? XIW'(LASTW - 1) : XIW'(BLOCKING - 1);
  assign last_addr = px && (x == XW'(NBLK - 1)) && (y == YW'(COL_SIZE - 1)) &&
                     (xi == xi_last);

  assign rd_addr = ADDRW'(px) * ADDRW'(HALF) + ADDRW'(y) * ADDRW'(ROW_SIZE) +
                   ADDRW'(x) * ADDRW'(BLOCKING) + ADDRW'(xi);

  assign occ        = skid_cnt + {1'b0, inflight};
  assign head_valid = (skid_cnt != 2'd0) || inflight;
  assign head_data  = (skid_cnt != 2'd0) ? skid[0] : rd_data;
  assign fifo_wenq  = head_valid && fifo_wfull_n;
  assign fifo_wdata = head_valid ? DATA_WIDTH'(head_data) : '0;

  // An arriving word that is not forwarded this cycle is stored.
  assign pop_buf = (skid_cnt != 2'd0) && fifo_wfull_n;
  assign push    = inflight && !((skid_cnt == 2'd0) && fifo_wfull_n);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking assignments here would create
  // order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (send_best_arr) begin
          busy      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy  = 1'b1;
        // Only issue when the skid buffer can absorb the read even if the
        // FIFO stalls.
        rd_en = (occ < 2'd2);
        if (rd_en && last_addr) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave once the only pending word, if any, is being enqueued now.
        if (occ == {1'b0, fifo_wenq}) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Loop counters. They wrap back to zero after the final address.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px <= 1'b0;
      x  <= '0;
      y  <= '0;
      xi <= '0;
    end else if (rd_en) begin
      if (xi == xi_last) begin
        xi <= '0;
        if (y == YW'(COL_SIZE - 1)) begin
          y <= '0;
          if (x == XW'(NBLK - 1)) begin
            x  <= '0;
            px <= ~px;
          end else begin
            x <= x + XW'(1);
          end
        end else begin
          y <= y + YW'(1);
        end
      end else begin
        xi <= xi + XIW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  // NOTE: the two data entries are reset along with the occupancy. This is
  // cheap at this size, and it keeps the buffer contents free of X after
  // reset. The occupancy alone already guarantees that stale data is never
  // sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      skid_cnt <= 2'd0;
      skid[0]  <= '0;
      skid[1]  <= '0;
    end else begin
      inflight <= rd_en;
      unique case ({push, pop_buf})
        2'b10: begin
          // When a word is arriving the occupancy is 0 or 1, never 2.
          skid[skid_cnt[0]] <= rd_data;
          skid_cnt          <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid[0]  <= skid[1];
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          // One entry is popped and the arriving word takes its place. The
          // occupancy stays the same.
          skid[0] <= rd_data;
        end
        default: ;
      endcase
    end
  end

`ifdef OUTSCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (state == S_IDLE && send_best_arr) begin
      stall_cycles <= '0;
    end else if (head_valid && !fifo_wfull_n) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_best_arr_out_sched.sv
// -----------------------------------------------------------------------------
// Testbench for best_arr_out_sched.
//
// The SRAM model returns each word's own address as its data. A reference
// model builds the expected word list from the loop-nest rules and pushes it
// into a scoreboard queue at every start. A monitor pops from the queue and
// compares on every fifo_wenq. Protocol rules are checked continuously:
// never more than two reads pending, and no enqueue while the FIFO is full.
// -----------------------------------------------------------------------------
module tb_best_arr_out_sched;

  localparam int DW    = 11;
  localparam int IW    = 9;
  localparam int ROW   = 26;
  localparam int COL   = 19;
  localparam int BLK   = 4;
  localparam int AW    = 9;
  localparam int HALF  = ROW / 2;
  localparam int TOTAL = ROW * COL;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          send_best_arr;
  logic          busy, done, rd_en, fifo_wenq;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_wfull_n;
`ifdef OUTSCHED_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  best_arr_out_sched #(
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .ROW_SIZE(ROW), .COL_SIZE(COL),
    .BLOCKING(BLK), .ADDRW(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .send_best_arr(send_best_arr),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .fifo_wenq    (fifo_wenq),
    .fifo_wdata   (fifo_wdata),
    .fifo_wfull_n (fifo_wfull_n)
`ifdef OUTSCHED_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, and each word holds its own address.
  always @(posedge clk) if (rd_en) rd_data <= rd_addr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and statistics
  logic [DW-1:0] exp_q[$];
  int            got_q[$];
  int            passed = 0;
  int            total  = 0;
  int            words, issued, enq, outstanding_viol, wenq_viol;
  int            done_cnt, done_cyc, last_wenq_cyc, first_wenq_cyc, start_cyc;
  bit            bp_random = 1'b0;
  string         cur_test = "reset";

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s/%s: got %0d expected %0d", cur_test, name, act, exp);
  endtask

  // Monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (issued - enq >= 2) outstanding_viol++;
        issued++;
      end
      if (fifo_wenq) begin
        if (!fifo_wfull_n) wenq_viol++;
        if (exp_q.size() == 0) begin
          check("extra_word", 32'(fifo_wdata), 32'hFFFF_FFFF);
        end else begin
          check("word", 32'(fifo_wdata), 32'(exp_q.pop_front()));
        end
        got_q.push_back(int'(fifo_wdata));
        words++;
        enq++;
        last_wenq_cyc = cyc;
        if (first_wenq_cyc < 0) first_wenq_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Random backpressure driver, with a 50% duty cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_random) fifo_wfull_n = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: the host-order walk, with out-of-range columns skipped.
  task automatic push_model();
    for (int px = 0; px < 2; px++)
      for (int x = 0; x * BLK < HALF; x++)
        for (int y = 0; y < COL; y++)
          for (int xi = 0; xi < BLK; xi++)
            if (x * BLK + xi < HALF)
              exp_q.push_back(DW'(px * HALF + y * ROW + x * BLK + xi));
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    exp_q.delete();
    got_q.delete();
    words = 0; issued = 0; enq = 0; outstanding_viol = 0; wenq_viol = 0;
    done_cnt = 0; done_cyc = -1; last_wenq_cyc = -1; first_wenq_cyc = -1;
  endtask

  task automatic start_xfer(input int hold);
    clear_stats();
    push_model();
    @(posedge clk);
    #1;
    send_best_arr = 1'b1;
    start_cyc     = cyc;
    #1;
    check("busy_on_start", 32'(busy), 32'd1);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    send_best_arr = 1'b0;
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 20000 && words < n; i++) tick();
    check("words_reached", 32'(words >= n), 32'd1);
  endtask

  task automatic finish_xfer();
    for (int i = 0; i < 20000 && done_cnt == 0; i++) tick();
    check("done_seen", 32'(done_cnt > 0), 32'd1);
    tick();
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (5) tick();
    check("word_count", 32'(words), 32'(TOTAL));
    check("done_once", 32'(done_cnt), 32'd1);
    check("done_timing", 32'(done_cyc), 32'(last_wenq_cyc + 1));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("max_outstanding", 32'(outstanding_viol), 32'd0);
    check("enq_while_full", 32'(wenq_viol), 32'd0);
  endtask

  function automatic int got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : -1;
  endfunction

  task automatic check_outputs_zero();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_wenq", 32'(fifo_wenq), 32'd0);
    check("rst_wdata", 32'(fifo_wdata), 32'd0);
`ifdef OUTSCHED_STALL_CNT_EN
    check("rst_stall", stall_cycles, 32'd0);
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    send_best_arr = 1'b0;
    fifo_wfull_n  = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero();
    @(negedge clk);
    rst_n = 1'b1;

    // Free-flowing stream, with the order spot-checked against known values
    cur_test = "stream";
    start_xfer(1);
    finish_xfer();
    check("first_latency", 32'(first_wenq_cyc - start_cyc), 32'd2);
    check("w0", 32'(got_at(0)), 32'd0);
    check("w3", 32'(got_at(3)), 32'd3);
    check("w4", 32'(got_at(4)), 32'd26);
    check("w76", 32'(got_at(76)), 32'd4);
    check("w80", 32'(got_at(80)), 32'd30);
    check("w228", 32'(got_at(228)), 32'd12);
    check("w229", 32'(got_at(229)), 32'd38);
    check("w247", 32'(got_at(247)), 32'd13);
    check("w250", 32'(got_at(250)), 32'd16);
    check("w493", 32'(got_at(493)), 32'd493);

    // Random backpressure
    cur_test = "random_bp";
    bp_random = 1'b1;
    start_xfer(1);
    finish_xfer();
    bp_random = 1'b0;
    @(posedge clk);
    #1;
    fifo_wfull_n = 1'b1;

    // Long stall in the middle of the stream
    cur_test = "long_stall";
    start_xfer(1);
    wait_words(100);
    @(posedge clk);
    #1;
    fifo_wfull_n = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    fifo_wfull_n = 1'b1;
    finish_xfer();
`ifdef OUTSCHED_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 32'd100);
`endif

    // Asynchronous reset in the middle of a transfer, then a clean restart
    cur_test = "mid_reset";
    start_xfer(1);
    wait_words(200);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero();
    @(negedge clk);
    rst_n = 1'b1;
    start_xfer(1);
    finish_xfer();
    check("restart_w0", 32'(got_at(0)), 32'd0);

    // Start pulses while busy are ignored
    cur_test = "restart_ignored";
    start_xfer(3);
    wait_words(50);
    @(posedge clk);
    #1;
    send_best_arr = 1'b1;
    @(posedge clk);
    #1;
    send_best_arr = 1'b0;
    finish_xfer();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
